// File: rtl/lpc_cycle_packer.sv
// lpc_cycle_packer
//   Buffers decoded LPC cycles in a small record FIFO and serializes each
//   record as a fixed-length byte frame on a valid/ready byte stream.
//
//   Frame layout, MSB first within each field:
//     byte0    {cyctype_dir[3:0], ovf_bit, data_size[2:0]}
//     byte1-4  addr[31:24] .. addr[7:0]
//     byte5-8  data[31:24] .. data[7:0]
//     byte9    XOR of bytes 0-8 (only when LPC_PACKER_CHECKSUM_EN is defined)
//
//   Optional build macro: LPC_PACKER_CHECKSUM_EN appends the checksum byte.
//
//   Handshake: a byte moves on every rising edge where tx_valid and tx_ready
//   are both high; while tx_valid is high and tx_ready is low, tx_valid and
//   tx_data hold their values.
//
// Ports
//   lpc_clock, lpc_reset    clock, synchronous active-high reset
//   in_cyctype_dir/addr/data/data_size, in_valid   decoded cycle + strobe
//   tx_data, tx_valid, tx_ready                     frame byte stream
//   fifo_level    records waiting in the FIFO (not counting the one being sent)
//   overflow      sticky drop flag, cleared when a header is loaded
//   drop_count    saturating count of dropped records
//   dbg_sending   FSM state for observation (1 = SEND, 0 = IDLE)
module lpc_cycle_packer #(
   parameter int DEPTH = 4
) (
   input  logic                     lpc_clock,
   input  logic                     lpc_reset,
   input  logic [3:0]               in_cyctype_dir,
   input  logic [31:0]              in_addr,
   input  logic [31:0]              in_data,
   input  logic [2:0]               in_data_size,
   input  logic                     in_valid,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic [7:0]               drop_count,
   output logic                     dbg_sending
);

   localparam int AW = $clog2(DEPTH);
`ifdef LPC_PACKER_CHECKSUM_EN
   localparam int NBYTES = 10;
`else
   localparam int NBYTES = 9;
`endif
   localparam int FW = NBYTES * 8;
   localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

   typedef struct packed {
      logic [3:0]  ctype;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  size;
   } rec_t;

   typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;

   rec_t            mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            ovf_q;
   logic [7:0]      drops_q;
   state_e          state_q, state_d;
   logic [3:0]      idx_q, idx_d;
   logic [FW-1:0]   frame_q, frame_d;

   logic            load;
   logic            empty, full;
   logic            wr_en, drop;
   rec_t            head;
   logic [71:0]     base;
`ifdef LPC_PACKER_CHECKSUM_EN
   logic [7:0]      csum;
`endif

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign head  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a record when the head is popped on the same edge.
   assign wr_en = in_valid && (!full || load);
   assign drop  = in_valid && full && !load;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      load    = 1'b0;
      // ovf_q is the pre-load value: a drop on the load edge is not seen here.
      base    = {head.ctype, ovf_q, head.size, head.addr, head.data};
`ifdef LPC_PACKER_CHECKSUM_EN
      csum    = 8'h00;
      for (int i = 0; i < 9; i++) begin
         csum = csum ^ base[i*8 +: 8];
      end
`endif
      case (state_q)
         S_IDLE: load = !empty;
         S_SEND: begin
            if (tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  // Back-to-back frames: reload on the last handshake.
                  if (!empty) load = 1'b1;
                  else        state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  frame_d = {frame_q[FW-9:0], 8'h00};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (load) begin
`ifdef LPC_PACKER_CHECKSUM_EN
         frame_d = {base, csum};
`else
         frame_d = base;
`endif
         idx_d   = 4'd0;
         state_d = S_SEND;
      end
   end

   always_ff @(posedge lpc_clock) begin
      if (lpc_reset) begin
         state_q  <= S_IDLE;
         idx_q    <= 4'd0;
         frame_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         drops_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (load)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_en && !load)      count_q <= count_q + 1'b1;
         else if (!wr_en && load) count_q <= count_q - 1'b1;
         // Drop wins over the clear from a simultaneous load.
         if (drop)      ovf_q <= 1'b1;
         else if (load) ovf_q <= 1'b0;
         if (drop && drops_q != 8'hFF) drops_q <= drops_q + 8'd1;
      end
   end

   // Record storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge lpc_clock) begin
      if (!lpc_reset && wr_en) begin
         mem_q[wr_ptr_q] <= '{ctype: in_cyctype_dir, addr: in_addr,
                              data: in_data, size: in_data_size};
      end
   end

   assign tx_valid    = (state_q == S_SEND);
   assign tx_data     = tx_valid ? frame_q[FW-1 -: 8] : 8'h00;
   assign fifo_level  = count_q;
   assign overflow    = ovf_q;
   assign drop_count  = drops_q;
   assign dbg_sending = (state_q == S_SEND);

endmodule

// File: tb/tb_lpc_cycle_packer.sv
module tb_lpc_cycle_packer;

   localparam int DEPTH = 4;
`ifdef LPC_PACKER_CHECKSUM_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif

   logic        clk = 1'b0;
   logic        lpc_reset;
   logic [3:0]  in_cyctype_dir;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [2:0]  in_data_size;
   logic        in_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [$clog2(DEPTH):0] fifo_level;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        dbg_sending;

   always #5 clk = ~clk;

   lpc_cycle_packer #(.DEPTH(DEPTH)) dut (
      .lpc_clock      (clk),
      .lpc_reset      (lpc_reset),
      .in_cyctype_dir (in_cyctype_dir),
      .in_addr        (in_addr),
      .in_data        (in_data),
      .in_data_size   (in_data_size),
      .in_valid       (in_valid),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .fifo_level     (fifo_level),
      .overflow       (overflow),
      .drop_count     (drop_count),
      .dbg_sending    (dbg_sending)
   );

   typedef struct packed {
      logic [3:0]  ct;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  size;
   } rec_t;

   logic [7:0] exp_q[$];
   rec_t       m_q[$];
   bit         m_busy;
   int         m_left;
   bit         m_ovf;
   int         m_drops;
   bit         checking = 1'b0;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected frame built from the field rules with integer arithmetic.
   function automatic void push_frame(input rec_t r, input bit ovf);
      int b[9];
      int cs;
      b[0] = int'(r.ct) * 16 + int'(ovf) * 8 + int'(r.size);
      for (int i = 0; i < 4; i++) begin
         b[1+i] = int'((r.addr >> (24 - 8*i)) & 32'hFF);
         b[5+i] = int'((r.data >> (24 - 8*i)) & 32'hFF);
      end
      cs = 0;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(8'(b[i]));
         cs = cs ^ b[i];
      end
      if (NB == 10) exp_q.push_back(8'(cs));
   endfunction

   // Reference model: records waiting, whether a frame is in flight and how
   // many of its bytes remain.
   always @(posedge clk) begin
      bit   hs, fin, ld, full, dr;
      rec_t r;
      if (lpc_reset) begin
         m_q.delete();
         exp_q.delete();
         m_busy  = 1'b0;
         m_left  = 0;
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         hs   = m_busy && tx_ready;
         fin  = hs && (m_left == 1);
         ld   = (m_q.size() > 0) && (!m_busy || fin);
         full = (m_q.size() == DEPTH);
         dr   = in_valid && full && !ld;
         if (ld) begin
            r = m_q.pop_front();
            push_frame(r, m_ovf);
            m_busy = 1'b1;
            m_left = NB;
         end else if (fin) begin
            m_busy = 1'b0;
         end else if (hs) begin
            m_left--;
         end
         if (dr) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end else if (ld) begin
            m_ovf = 1'b0;
         end
         if (in_valid && !dr)
            m_q.push_back('{ct: in_cyctype_dir, addr: in_addr, data: in_data, size: in_data_size});
      end
   end

   // Monitor: compares status against the model and pops one expected byte
   // for every accepted stream byte.
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   always @(negedge clk) begin
      logic [7:0] e;
      if (checking) begin
         chk("tx_valid", 32'(tx_valid), 32'(m_busy));
         chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("drop_count", 32'(drop_count), 32'(m_drops));
         if (prev_stall) begin
            chk("stall_valid_hold", 32'(tx_valid), 32'd1);
            chk("stall_data_hold", 32'(tx_data), 32'(prev_data));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("tx_byte", 32'(tx_data), 32'(e));
            end
         end
         prev_stall = tx_valid && !tx_ready && !lpc_reset;
         prev_data  = tx_data;
      end
   end

   task automatic strobe(input logic [3:0] ct, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
      in_cyctype_dir = ct;
      in_addr        = a;
      in_data        = d;
      in_data_size   = s;
      in_valid       = 1'b1;
      @(posedge clk); #1;
      in_valid       = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      tx_ready = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!tx_valid && exp_q.size() == 0 && m_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain_timeout", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int run;
      lpc_reset      = 1'b1;
      in_valid       = 1'b0;
      in_cyctype_dir = 4'h0;
      in_addr        = 32'h0;
      in_data        = 32'h0;
      in_data_size   = 3'd0;
      tx_ready       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      lpc_reset = 1'b0;
      checking  = 1'b1;

      // Reset state
      @(negedge clk);
      chk("reset_tx_data", 32'(tx_data), 32'h00);
      chk("reset_tx_valid", 32'(tx_valid), 32'd0);
      @(posedge clk); #1;

      // Single IO write with latency check
      strobe(4'b0010, 32'h0000_7fe5, 32'h0000_006c, 3'd1);
      @(negedge clk);
      chk("latency_not_yet", 32'(tx_valid), 32'd0);
      @(negedge clk);
      chk("latency_first", 32'(tx_valid), 32'd1);
      chk("io_header", 32'(tx_data), 32'h21);
      @(posedge clk); #1;
      wait_idle();

      // Back-pressure: tx_ready toggling every cycle
      strobe(4'b0010, 32'h0000_7fe5, 32'h0000_006c, 3'd1);
      for (int i = 0; i < 30; i++) begin
         tx_ready = i[0];
         @(posedge clk); #1;
      end
      wait_idle();

      // Overflow: six strobes with the sink stalled
      tx_ready = 1'b0;
      for (int i = 1; i <= 6; i++) strobe(4'h4, 32'(i), 32'h1000 + 32'(i), 3'd4);
      @(negedge clk);
      chk("ovf_level", 32'(fifo_level), 32'd4);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_drops", 32'(drop_count), 32'd1);
      @(posedge clk); #1;
      wait_idle();

      // Full FIFO: write lands on the same edge as the last-byte handshake
      tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) strobe(4'h6, 32'h100 + 32'(i), 32'(i), 3'd2);
      tx_ready = 1'b1;
      repeat (NB - 1) begin
         @(posedge clk); #1;
      end
      strobe(4'h6, 32'h200, 32'hABCD, 3'd2);
      @(negedge clk);
      chk("simul_level", 32'(fifo_level), 32'd4);
      chk("simul_drops", 32'(drop_count), 32'd1);
      @(posedge clk); #1;
      wait_idle();

      // Back-to-back frames
      strobe(4'h3, 32'hDEAD_BEEF, 32'h1234_5678, 3'd4);
      strobe(4'h3, 32'hCAFE_F00D, 32'h8765_4321, 3'd4);
      run = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_valid) run++;
         else if (run > 0) break;
      end
      chk("b2b_run", 32'(run), 32'(2 * NB));
      @(posedge clk); #1;
      wait_idle();

      // Reset mid-frame with records queued
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) strobe(4'h7, 32'h300 + 32'(i), 32'(i), 3'd1);
      tx_ready = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      lpc_reset = 1'b1;
      @(posedge clk); #1;
      lpc_reset = 1'b0;
      @(negedge clk);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drops", 32'(drop_count), 32'd0);
      @(posedge clk); #1;
      strobe(4'b0010, 32'h0000_7fe5, 32'h0000_006c, 3'd1);
      wait_idle();

      // Randomized traffic with random back-pressure
      for (int i = 0; i < 400; i++) begin
         tx_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) < 3) begin
            in_cyctype_dir = 4'($urandom_range(0, 15));
            in_addr        = $urandom;
            in_data        = $urandom;
            in_data_size   = 3'($urandom_range(0, 4));
            in_valid       = 1'b1;
         end else begin
            in_valid       = 1'b0;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lpc_cycle_packer.md
Name: lpc_cycle_packer

Overview:
- Downstream consumer of the LPC cycle decoder.
- Captures each decoded cycle (cycle type/direction, address, data, data size) on the decoder's one-cycle valid strobe and buffers it in a small record FIFO.
- Serializes each record as a fixed-length byte frame over a valid/ready byte stream, which feeds the UART transmitter.

Parameters:
- DEPTH, 4, number of cycle records buffered; power of two, minimum 2.

Ports:
- lpc_clock  input  1  system clock; all logic on rising edge.
- lpc_reset  input  1  synchronous, active-high reset.
- in_cyctype_dir  input  4  decoded cycle type/direction, same encoding as decoder out_cyctype_dir.
- in_addr  input  32  decoded address.
- in_data  input  32  decoded data; a 1-byte cycle uses in_data[7:0].
- in_data_size  input  3  number of valid data bytes (0-4).
- in_valid  input  1  one-cycle strobe from decoder out_clock_enable; sampled synchronously.
- tx_data  output  8  current frame byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  sink accepts the byte when tx_valid and tx_ready are both high.
- fifo_level  output  $clog2(DEPTH)+1  records currently in FIFO, excluding the record being sent.
- overflow  output  1  sticky: a record was dropped since the last header was loaded.
- drop_count  output  8  total dropped records, saturating at 255.

Behaviour:
- Reset values:
  - tx_valid=0, tx_data=0x00.
  - fifo_level=0, overflow=0, drop_count=0.
  - FIFO empty, serializer in IDLE.
- Frame is 9 bytes, MSB first within each field:
  - byte0 header = {cyctype_dir[3:0], ovf_bit, data_size[2:0]}.
  - bytes1-4 = addr[31:24], addr[23:16], addr[15:8], addr[7:0].
  - bytes5-8 = data[31:24] ... data[7:0].
- FIFO write:
  - in_valid && (!full || load this cycle) → record written at the rising edge.
  - Load and write in the same cycle while full: both succeed, level unchanged.
- Drop:
  - in_valid && full && no load → record discarded.
  - overflow set to 1; drop_count incremented, holding at 255.
- Serializer states:
  - IDLE: if FIFO non-empty → load the head record into the shift register, pop the FIFO, idx=0, go SEND.
  - SEND: tx_valid=1, tx_data=byte[idx].
    - On handshake, idx+1.
    - On handshake of the last byte: if FIFO non-empty, load the next record in the same cycle (back-to-back frames, no idle cycle); else go IDLE and drop tx_valid in the next cycle.
- ovf_bit is the overflow value at load time.
  - Loading a record clears overflow.
  - A drop in the same cycle as a load wins: overflow stays 1, and the loaded header carries the pre-load value.
- Latency:
  - in_valid sampled at edge N with FIFO empty and IDLE → loaded at edge N+1 → tx_valid=1 with byte0 during cycle N+1→N+2.
  - Minimum 1 cycle per byte when tx_ready is held high.
- Stability: while tx_valid && !tx_ready, tx_data and tx_valid hold.
- Capacity: DEPTH records in the FIFO plus 1 in the shift register.
- Reset mid-operation:
  - The frame in flight is aborted and the FIFO is flushed.
  - tx_valid=0 from the edge where lpc_reset is sampled high.
  - Counters are cleared.
- in_valid during reset is ignored.

Optional Feature:
- Macro LPC_PACKER_CHECKSUM_EN.
- Defined: frame is 10 bytes; byte9 = XOR of bytes0-8. The last-byte rule applies to byte9.
- Undefined: frame is 9 bytes; no checksum logic.

Test Plan:
- Single IO write: in_cyctype_dir=4'b0010, addr=0x7fe5, data=0x6c, size=1, tx_ready=1 → bytes 0x21,0x00,0x00,0x7F,0xE5,0x00,0x00,0x00,0x6C. With checksum enabled, an extra byte 0xD7. tx_valid first high 1 cycle after the sampled strobe.
- Back-pressure: same record, tx_ready toggled 1/0 every cycle → identical byte sequence; tx_data stable during every stalled cycle.
- Overflow, DEPTH=4, tx_ready=0, six in_valid strobes with addr 1..6 → 5 accepted (1 in shift register, 4 in FIFO), fifo_level=4, overflow=1, drop_count=1. Release tx_ready → frames addr 1..5 in order; frame 1 header bit3=0, frame 2 header bit3=1, overflow=0 after frame 2 loads.
- Simultaneous full write and load: FIFO full, last byte handshaked in the same cycle as in_valid → no drop, fifo_level stays DEPTH, drop_count unchanged.
- Back-to-back: two records queued, tx_ready=1 → 18 consecutive tx_valid cycles with no gap.
- Reset mid-frame: assert lpc_reset during byte 4 of a frame with 2 records queued → tx_valid=0 on the next edge, fifo_level=0, overflow=0, drop_count=0. The next strobe after reset produces a clean frame.
